// File: rtl/ndma_obi_sub_mem.sv
// OBI subordinate word-addressed scratch memory with fixed response latency,
// bounded outstanding transactions, periodic grant stalls and range errors.
module ndma_obi_sub_mem #(
  parameter int unsigned NumWords       = 1024,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned Latency        = 1,
  parameter int unsigned MaxOutstanding = 2,
  parameter int unsigned GntStallPeriod = 0
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic                                   obi_req_i,
  output logic                                   obi_gnt_o,
  input  logic [31:0]                            obi_addr_i,
  input  logic                                   obi_we_i,
  input  logic [DataWidth/8-1:0]                 obi_be_i,
  input  logic [DataWidth-1:0]                   obi_wdata_i,
  output logic                                   obi_rvalid_o,
  output logic [DataWidth-1:0]                   obi_rdata_o,
  output logic                                   obi_err_o,
  output logic [$clog2(MaxOutstanding+1)-1:0]    outstanding_o
);

  localparam int unsigned AW = $clog2(NumWords);
  localparam int unsigned OW = $clog2(MaxOutstanding + 1);
  localparam int unsigned SW = (GntStallPeriod > 0) ? $clog2(GntStallPeriod + 1) : 1;
  localparam int unsigned NB = DataWidth / 8;
  localparam logic [OW-1:0] MaxOut  = OW'(MaxOutstanding);
  localparam logic [SW-1:0] StallAt = SW'(GntStallPeriod);

  typedef struct packed {
    logic                 err;
    logic [DataWidth-1:0] rdata;
  } rsp_t;

  logic [DataWidth-1:0] mem_q [NumWords];

  logic [Latency-1:0] vld_pipe_q, vld_pipe_d;
  rsp_t [Latency-1:0] rsp_pipe_q, rsp_pipe_d;
  logic [OW-1:0]      outst_q, outst_d;
  logic [SW-1:0]      stall_cnt_q, stall_cnt_d;

  logic          stall, acc, in_range, rsp_vld;
  logic [AW-1:0] widx;
  rsp_t          rsp_new;
  logic          unused_addr_lsb;

  assign widx            = obi_addr_i[AW+1:2];
  assign unused_addr_lsb = ^obi_addr_i[1:0];

  // NumWords is a power of two, so addr < NumWords*4 reduces to "upper bits clear".
  if (AW + 2 < 32) begin : g_range
    assign in_range = ~|obi_addr_i[31:AW+2];
  end else begin : g_full_range
    assign in_range = 1'b1;
  end

  assign stall     = (GntStallPeriod != 0) && (stall_cnt_q == StallAt);
  assign obi_gnt_o = obi_req_i && (outst_q < MaxOut) && !stall;
  assign acc       = obi_req_i && obi_gnt_o;
  assign rsp_vld   = vld_pipe_q[Latency-1];

  always_comb begin
    rsp_new = '0;
    rsp_new.err = !in_range;
    if (!obi_we_i && in_range) rsp_new.rdata = mem_q[widx];

    vld_pipe_d    = vld_pipe_q;
    rsp_pipe_d    = rsp_pipe_q;
    vld_pipe_d[0] = acc;
    // Bubbles carry zero so rdata/err stay 0 whenever rvalid is low.
    rsp_pipe_d[0] = acc ? rsp_new : '0;
    for (int i = 1; i < Latency; i++) begin
      vld_pipe_d[i] = vld_pipe_q[i-1];
      rsp_pipe_d[i] = rsp_pipe_q[i-1];
    end

    outst_d = outst_q;
    if (acc && !rsp_vld)      outst_d = outst_q + 1'b1;
    else if (!acc && rsp_vld) outst_d = outst_q - 1'b1;

    stall_cnt_d = stall_cnt_q;
    if (GntStallPeriod == 0)      stall_cnt_d = '0;
    else if (stall && obi_req_i)  stall_cnt_d = '0;
    else if (acc)                 stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_pipe_q  <= '0;
      rsp_pipe_q  <= '0;
      outst_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      vld_pipe_q  <= vld_pipe_d;
      rsp_pipe_q  <= rsp_pipe_d;
      outst_q     <= outst_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Storage is deliberately not reset: contents survive rst_ni.
  always_ff @(posedge clk_i) begin
    if (acc && obi_we_i && in_range) begin
      for (int b = 0; b < NB; b++) begin
        if (obi_be_i[b]) mem_q[widx][8*b +: 8] <= obi_wdata_i[8*b +: 8];
      end
    end
  end

  assign obi_rvalid_o  = rsp_vld;
  assign obi_rdata_o   = rsp_pipe_q[Latency-1].rdata;
  assign obi_err_o     = rsp_pipe_q[Latency-1].err;
  assign outstanding_o = outst_q;

  a_outst_cap: assert property (@(posedge clk_i) disable iff (!rst_ni) outst_q <= MaxOut);
  a_outst_uflow: assert property (@(posedge clk_i) disable iff (!rst_ni) !(outst_q == '0 && rsp_vld));

endmodule

// File: tb/tb_ndma_obi_sub_mem.sv
// Bench for ndma_obi_sub_mem: three instances (lat1, lat3, lat1+stall4) driven
// from vector tables and short sequences, responses checked through a scoreboard.
module tb_ndma_obi_sub_mem;
  localparam int ND = 3;
  localparam int LAT [ND] = '{1, 3, 1};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n [ND], req [ND], gnt [ND], we [ND], rvalid [ND], err [ND], exp_er [ND];
  logic [31:0] addr [ND], wdata [ND], rdata [ND], exp_rd [ND];
  logic [3:0]  be [ND];
  logic [1:0]  outst [ND];

  ndma_obi_sub_mem #(.NumWords(1024), .Latency(1), .MaxOutstanding(2), .GntStallPeriod(0)) u_a (
    .clk_i(clk), .rst_ni(rst_n[0]), .obi_req_i(req[0]), .obi_gnt_o(gnt[0]), .obi_addr_i(addr[0]),
    .obi_we_i(we[0]), .obi_be_i(be[0]), .obi_wdata_i(wdata[0]), .obi_rvalid_o(rvalid[0]),
    .obi_rdata_o(rdata[0]), .obi_err_o(err[0]), .outstanding_o(outst[0]));
  ndma_obi_sub_mem #(.NumWords(1024), .Latency(3), .MaxOutstanding(2), .GntStallPeriod(0)) u_b (
    .clk_i(clk), .rst_ni(rst_n[1]), .obi_req_i(req[1]), .obi_gnt_o(gnt[1]), .obi_addr_i(addr[1]),
    .obi_we_i(we[1]), .obi_be_i(be[1]), .obi_wdata_i(wdata[1]), .obi_rvalid_o(rvalid[1]),
    .obi_rdata_o(rdata[1]), .obi_err_o(err[1]), .outstanding_o(outst[1]));
  ndma_obi_sub_mem #(.NumWords(1024), .Latency(1), .MaxOutstanding(2), .GntStallPeriod(4)) u_c (
    .clk_i(clk), .rst_ni(rst_n[2]), .obi_req_i(req[2]), .obi_gnt_o(gnt[2]), .obi_addr_i(addr[2]),
    .obi_we_i(we[2]), .obi_be_i(be[2]), .obi_wdata_i(wdata[2]), .obi_rvalid_o(rvalid[2]),
    .obi_rdata_o(rdata[2]), .obi_err_o(err[2]), .outstanding_o(outst[2]));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0, n_fail = 0;
  int maxo [ND];
  int full_viol = 0;
  logic        hold [ND];
  logic [31:0] haddr [ND];

  typedef struct {
    int          d;
    logic [31:0] rdata;
    logic        err;
    int          due;
  } exp_t;
  exp_t sb[$];
  bit   glog[$];

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rd;
    bit          er;
  } vec_t;
  vec_t tbl [15];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Monitor: push expectations on acceptance, pop and compare on rvalid.
  always @(negedge clk) begin
    exp_t e;
    for (int d = 0; d < ND; d++) begin
      if (hold[d] && req[d])
        assert (addr[d] == haddr[d]) else $error("protocol: port %0d addr changed before grant", d);
      hold[d]  = req[d] && !gnt[d];
      haddr[d] = addr[d];
      if (req[d]) glog.push_back(gnt[d]);
      if (int'(outst[d]) > maxo[d]) maxo[d] = int'(outst[d]);
      if (req[d] && gnt[d]) begin
        if (outst[d] == 2'd2) full_viol++;
        sb.push_back('{d, exp_rd[d], exp_er[d], cyc + LAT[d]});
      end
      if (rvalid[d]) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_rvalid: port %0d rvalid=1 at cycle %0d, want 0", d, cyc);
        end else begin
          e = sb.pop_front();
          check("rsp_port", 32'(d), 32'(e.d));
          check("rsp_rdata", rdata[d], e.rdata);
          check("rsp_err", 32'(err[d]), 32'(e.err));
          check("rsp_latency", 32'(cyc), 32'(e.due));
        end
      end
    end
  end

  // Entered and left at posedge+#1; req stays high so calls chain back-to-back.
  task automatic issue(input int d, input bit w, input logic [31:0] a, input logic [3:0] b,
                       input logic [31:0] wd, input logic [31:0] erd, input bit eer);
    int n = 0;
    req[d] = 1'b1; we[d] = w; addr[d] = a; be[d] = b; wdata[d] = wd;
    exp_rd[d] = erd; exp_er[d] = eer;
    forever begin
      @(negedge clk);
      if (gnt[d]) break;
      n++;
      if (n > 40) begin
        n_tests++;
        n_fail++;
        $display("FAIL grant_timeout: port %0d addr 0x%08h no gnt in 40 cycles, want gnt", d, a);
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: %0d responses missing, want 0", sb.size());
      sb.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rv;
    tbl[0]  = '{1'b1, 32'h0000_0010, 4'hF, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
    tbl[1]  = '{1'b0, 32'h0000_0010, 4'hF, 32'h0,         32'hDEAD_BEEF, 1'b0};
    tbl[2]  = '{1'b1, 32'h0000_0020, 4'hF, 32'h1122_3344, 32'h0000_0000, 1'b0};
    tbl[3]  = '{1'b1, 32'h0000_0020, 4'h5, 32'hAABB_CCDD, 32'h0000_0000, 1'b0};
    tbl[4]  = '{1'b0, 32'h0000_0020, 4'h0, 32'h0,         32'h11BB_33DD, 1'b0};
    tbl[5]  = '{1'b1, 32'h0000_0020, 4'h0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
    tbl[6]  = '{1'b0, 32'h0000_0020, 4'hF, 32'h0,         32'h11BB_33DD, 1'b0};
    tbl[7]  = '{1'b1, 32'h0000_0000, 4'hF, 32'h5A5A_5A5A, 32'h0000_0000, 1'b0};
    tbl[8]  = '{1'b0, 32'h0000_1000, 4'hF, 32'h0,         32'h0000_0000, 1'b1};
    tbl[9]  = '{1'b1, 32'h0000_1004, 4'hF, 32'h1234_5678, 32'h0000_0000, 1'b1};
    tbl[10] = '{1'b0, 32'h0000_0000, 4'hF, 32'h0,         32'h5A5A_5A5A, 1'b0};
    tbl[11] = '{1'b1, 32'h0000_0FFC, 4'hF, 32'hCAFE_F00D, 32'h0000_0000, 1'b0};
    tbl[12] = '{1'b0, 32'h0000_0FFC, 4'hF, 32'h0,         32'hCAFE_F00D, 1'b0};
    tbl[13] = '{1'b0, 32'h0000_0013, 4'hF, 32'h0,         32'hDEAD_BEEF, 1'b0};
    tbl[14] = '{1'b0, 32'h8000_0010, 4'hF, 32'h0,         32'h0000_0000, 1'b1};

    for (int d = 0; d < ND; d++) begin
      rst_n[d] = 1'b0; req[d] = 1'b0; we[d] = 1'b0; addr[d] = '0; be[d] = '0;
      wdata[d] = '0; exp_rd[d] = '0; exp_er[d] = 1'b0; hold[d] = 1'b0; maxo[d] = 0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      check("reset_gnt", 32'(gnt[d]), 32'd0);
      check("reset_rvalid", 32'(rvalid[d]), 32'd0);
      check("reset_rdata", rdata[d], 32'd0);
      check("reset_err", 32'(err[d]), 32'd0);
      check("reset_outst", 32'(outst[d]), 32'd0);
    end
    @(posedge clk); #1;
    for (int d = 0; d < ND; d++) rst_n[d] = 1'b1;
    @(posedge clk); #1;

    // Vector table on the latency-1 instance, issued back-to-back.
    foreach (tbl[i]) issue(0, tbl[i].we, tbl[i].addr, tbl[i].be, tbl[i].wdata, tbl[i].rd, tbl[i].er);
    req[0] = 1'b0;
    drain();

    // Grant stall every 4 acceptances, 10 continuous requests.
    glog.delete();
    for (int i = 0; i < 5; i++) issue(2, 1'b1, 32'(i * 4), 4'hF, 32'hC0DE_0000 + 32'(i), 32'h0, 1'b0);
    for (int i = 0; i < 5; i++) issue(2, 1'b0, 32'(i * 4), 4'hF, 32'h0, 32'hC0DE_0000 + 32'(i), 1'b0);
    req[2] = 1'b0;
    drain();
    check("stall_req_cycles", 32'(glog.size()), 32'd12);
    for (int i = 0; i < 12 && i < glog.size(); i++)
      check("stall_gnt_pattern", 32'(glog[i]), (i == 4 || i == 9) ? 32'd0 : 32'd1);

    // Latency 3 with two outstanding: fill, then stream six reads.
    for (int i = 0; i < 6; i++) issue(1, 1'b1, 32'h100 + 32'(i * 4), 4'hF, 32'hB000_0000 + 32'(i), 32'h0, 1'b0);
    req[1] = 1'b0;
    drain();
    glog.delete();
    maxo[1] = 0;
    full_viol = 0;
    for (int i = 0; i < 6; i++) issue(1, 1'b0, 32'h100 + 32'(i * 4), 4'hF, 32'h0, 32'hB000_0000 + 32'(i), 1'b0);
    req[1] = 1'b0;
    drain();
    check("lat3_max_outst", 32'(maxo[1]), 32'd2);
    check("lat3_gnt_when_full", 32'(full_viol), 32'd0);
    if (glog.size() >= 3) begin
      check("lat3_gnt0", 32'(glog[0]), 32'd1);
      check("lat3_gnt1", 32'(glog[1]), 32'd1);
      check("lat3_gnt2_blocked", 32'(glog[2]), 32'd0);
    end else begin
      check("lat3_req_cycles", 32'(glog.size()), 32'd3);
    end

    // Reset with two reads in flight.
    issue(1, 1'b1, 32'h40, 4'hF, 32'h0BAD_CAFE, 32'h0, 1'b0);
    req[1] = 1'b0;
    drain();
    issue(1, 1'b0, 32'h40, 4'hF, 32'h0, 32'h0, 1'b0);
    issue(1, 1'b0, 32'h104, 4'hF, 32'h0, 32'h0, 1'b0);
    req[1] = 1'b0;
    rst_n[1] = 1'b0;
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst_n[1] = 1'b1;
    rv = 0;
    repeat (6) begin
      @(negedge clk);
      if (rvalid[1]) rv++;
    end
    check("rst_no_rvalid", 32'(rv), 32'd0);
    check("rst_outst", 32'(outst[1]), 32'd0);
    @(posedge clk); #1;
    issue(1, 1'b0, 32'h40, 4'hF, 32'h0, 32'h0BAD_CAFE, 1'b0);
    issue(1, 1'b0, 32'h108, 4'hF, 32'h0, 32'hB000_0002, 1'b0);
    req[1] = 1'b0;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
